eth_stats_snapshot_fifo: RTL and testbench
==========================================

ETH_STATS_SNAPSHOT_FIFO -- requirements
Module: eth_stats_snapshot_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64: snapshot entries held; power of two, 2..32768.
REQ-002 SHALL have parameter USE_TIME, default 1: 1 stores current_time in each entry, 0 stores 64'd0.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port srst, input, 1: synchronous software reset, active high.
REQ-006 SHALL have port enable, input, 1: capture enable.
REQ-007 SHALL have port current_time, input, 64: reference timer value.
REQ-008 SHALL have ports tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad, input, 64 each: running totals from the statistics adders.
REQ-009 SHALL have port pop, input, 1: one-cycle request to load the oldest entry into the output registers.
REQ-010 SHALL have ports out_time, out_tx_bytes, out_tx_good, out_tx_bad, out_rx_bytes, out_rx_good, out_rx_bad, output, 64 each: last popped snapshot.
REQ-011 SHALL have port occupancy, output, 16: entries currently stored.
REQ-012 SHALL have port overflow, output, 1: sticky flag, set when a snapshot was dropped.

Function
REQ-013 SHALL keep a registered copy (prev) of the six input totals, updated every cycle regardless of enable.
REQ-014 SHALL raise change when any of the six inputs differs from prev in the same cycle.
REQ-015 SHALL push one entry {time, six totals} in the cycle after change=1 with enable=1, using the time and totals sampled in the change cycle; one push per change cycle, back-to-back pushes allowed.
REQ-016 SHALL ignore change when enable=0; no push, prev still updates.
REQ-017 SHALL drop the push when the FIFO is full and no pop occurs in that cycle, set overflow, and leave contents unchanged.
REQ-018 SHALL perform push and pop together in one cycle when both are requested and the FIFO is non-empty; occupancy unchanged; when full, push succeeds with no overflow.
REQ-019 SHALL load the oldest entry into out_* registers on the clock edge after pop=1 with occupancy>0, and decrement occupancy on that edge.
REQ-020 SHALL ignore pop when occupancy=0; out_* hold their value, no underflow.
REQ-021 SHALL wrap read and write pointers modulo FIFO_DEPTH; occupancy ranges 0..FIFO_DEPTH.
REQ-022 SHALL make push-when-empty with simultaneous pop read the old contents, i.e. pop ignored, push completes, occupancy becomes 1.
REQ-023 SHALL hold out_* between pops; they never change on push.
REQ-024 SHALL clear overflow only by reset or srst.
REQ-025 SHALL store entry storage in memory inferable as block RAM; no reset on storage array.

Reset
REQ-026 SHALL, while rst_n=0 (asynchronously) or on a clock edge with srst=1, clear pointers, occupancy, overflow, out_* and prev to 0.
REQ-027 SHALL discard any pending push or pop on reset mid-operation; first push possible only on the cycle after the first change seen post-reset.
REQ-028 SHALL treat nonzero inputs on the first cycle after reset as change relative to prev=0.

Verification
REQ-029 Reset, enable=1, tx_good steps 0->1 at time 100 -> occupancy=1 one cycle later; pop -> out_tx_good=1, out_time=100, occupancy=0.
REQ-030 enable=0, counters change 5 times -> occupancy stays 0, overflow=0.
REQ-031 FIFO_DEPTH=4, 5 consecutive changes, no pop -> occupancy=4, overflow=1; 4 pops return first 4 snapshots in order; 5th pop leaves out_* unchanged.
REQ-032 Full FIFO, change and pop in same cycle -> occupancy stays 4, overflow stays 0, oldest entry emitted.
REQ-033 Pop on empty FIFO -> out_* and occupancy unchanged.
REQ-034 3 entries stored, srst pulse -> occupancy=0, overflow=0, out_*=0; next change yields occupancy=1.

Source files
------------

// File: rtl/eth_stats_snapshot_fifo.sv
// ---------------------------------------------------------------------------
// eth_stats_snapshot_fifo
//
// Watches six running Ethernet statistics totals. Whenever any of them moves,
// a snapshot {time, tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad} is
// queued into a FIFO held in block RAM. Software pops snapshots one at a time
// into the out_* holding registers.
//
// Parameters
//   FIFO_DEPTH : snapshot entries held (power of two, 2..32768)
//   USE_TIME   : 1 stores current_time in each entry, 0 stores zero
//
// Ports
//   clk, rst_n (async, active low), srst (sync, active high)
//   enable         : capture enable
//   current_time   : reference timer value
//   tx_*/rx_*      : running totals (64 bit each)
//   pop            : load the oldest entry into out_* on the next edge
//   out_*          : last popped snapshot
//   occupancy      : entries currently stored
//   overflow       : sticky, set when a snapshot was dropped on a full FIFO
// ---------------------------------------------------------------------------
module eth_stats_snapshot_fifo #(
    parameter int FIFO_DEPTH = 64,
    parameter int USE_TIME   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        enable,
    input  logic [63:0] current_time,
    input  logic [63:0] tx_bytes,
    input  logic [63:0] tx_good,
    input  logic [63:0] tx_bad,
    input  logic [63:0] rx_bytes,
    input  logic [63:0] rx_good,
    input  logic [63:0] rx_bad,
    input  logic        pop,
    output logic [63:0] out_time,
    output logic [63:0] out_tx_bytes,
    output logic [63:0] out_tx_good,
    output logic [63:0] out_tx_bad,
    output logic [63:0] out_rx_bytes,
    output logic [63:0] out_rx_good,
    output logic [63:0] out_rx_bad,
    output logic [15:0] occupancy,
    output logic        overflow
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          EW        = 7 * 64;
    localparam logic [15:0] DEPTH_OCC = 16'(FIFO_DEPTH);

    logic [63:0]   cur_total [6];
    logic [63:0]   prev_reg  [6];
    logic [5:0]    diff;
    logic          change;

    logic          push_pending_reg;
    logic [63:0]   stage_time_reg;
    logic [63:0]   time_sample;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [15:0]   occ_reg;
    logic          overflow_reg;
    logic [EW-1:0] out_entry_reg;
    logic [EW-1:0] wr_data;
    logic          do_push;
    logic          do_pop;

    logic [EW-1:0] mem [FIFO_DEPTH];

    assign cur_total[0] = tx_bytes;
    assign cur_total[1] = tx_good;
    assign cur_total[2] = tx_bad;
    assign cur_total[3] = rx_bytes;
    assign cur_total[4] = rx_good;
    assign cur_total[5] = rx_bad;

    // prev follows the inputs every cycle, independent of enable, so a change
    // seen while disabled is not replayed once enable returns.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_prev
            assign diff[gi] = (cur_total[gi] != prev_reg[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_reg[gi] <= '0;
                end else if (srst) begin
                    prev_reg[gi] <= '0;
                end else begin
                    prev_reg[gi] <= cur_total[gi];
                end
            end
        end
    endgenerate

    assign change = |diff;

    generate
        if (USE_TIME != 0) begin : g_time
            assign time_sample = current_time;
        end else begin : g_no_time
            assign time_sample = '0;
        end
    endgenerate

    // In the push cycle prev_reg already holds the totals sampled in the
    // change cycle, so only the timestamp needs its own staging register.
    assign wr_data = {stage_time_reg, prev_reg[0], prev_reg[1], prev_reg[2],
                      prev_reg[3], prev_reg[4], prev_reg[5]};

    // A pop on an empty FIFO is ignored even if a push lands in that cycle.
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    assign do_pop  = pop && (occ_reg != 16'd0);
    assign do_push = push_pending_reg && ((occ_reg != DEPTH_OCC) || do_pop);

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push && !srst) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_pending_reg <= 1'b0;
            stage_time_reg   <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            occ_reg          <= '0;
            overflow_reg     <= 1'b0;
            out_entry_reg    <= '0;
        end else if (srst) begin
            push_pending_reg <= 1'b0;
            stage_time_reg   <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            occ_reg          <= '0;
            overflow_reg     <= 1'b0;
            out_entry_reg    <= '0;
        end else begin
            push_pending_reg <= change && enable;
            stage_time_reg   <= time_sample;

            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end

            // Read-first: when full, push and pop share an address and the
            // old (oldest) entry is what gets emitted.
            if (do_pop) begin
                rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                out_entry_reg <= mem[rd_ptr_reg];
            end

            if (do_push && !do_pop) begin
                occ_reg <= occ_reg + 16'd1;
            end else if (do_pop && !do_push) begin
                occ_reg <= occ_reg - 16'd1;
            end

            if (push_pending_reg && !do_push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out_time     = out_entry_reg[6*64 +: 64];
    assign out_tx_bytes = out_entry_reg[5*64 +: 64];
    assign out_tx_good  = out_entry_reg[4*64 +: 64];
    assign out_tx_bad   = out_entry_reg[3*64 +: 64];
    assign out_rx_bytes = out_entry_reg[2*64 +: 64];
    assign out_rx_good  = out_entry_reg[1*64 +: 64];
    assign out_rx_bad   = out_entry_reg[0*64 +: 64];
    assign occupancy    = occ_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_eth_stats_snapshot_fifo.sv
// ---------------------------------------------------------------------------
// tb_eth_stats_snapshot_fifo
//
// Directed bench for eth_stats_snapshot_fifo with FIFO_DEPTH=4. Inputs are
// driven on the falling edge and outputs are sampled on the falling edge, so
// every rising edge sees stable stimulus.
// ---------------------------------------------------------------------------
module tb_eth_stats_snapshot_fifo;

    logic        clk;
    logic        rst_n;
    logic        srst;
    logic        enable;
    logic [63:0] current_time;
    logic [63:0] tx_bytes;
    logic [63:0] tx_good;
    logic [63:0] tx_bad;
    logic [63:0] rx_bytes;
    logic [63:0] rx_good;
    logic [63:0] rx_bad;
    logic        pop;
    logic [63:0] out_time;
    logic [63:0] out_tx_bytes;
    logic [63:0] out_tx_good;
    logic [63:0] out_tx_bad;
    logic [63:0] out_rx_bytes;
    logic [63:0] out_rx_good;
    logic [63:0] out_rx_bad;
    logic [15:0] occupancy;
    logic        overflow;

    int tests_run;
    int tests_failed;

    eth_stats_snapshot_fifo #(
        .FIFO_DEPTH (4),
        .USE_TIME   (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .srst         (srst),
        .enable       (enable),
        .current_time (current_time),
        .tx_bytes     (tx_bytes),
        .tx_good      (tx_good),
        .tx_bad       (tx_bad),
        .rx_bytes     (rx_bytes),
        .rx_good      (rx_good),
        .rx_bad       (rx_bad),
        .pop          (pop),
        .out_time     (out_time),
        .out_tx_bytes (out_tx_bytes),
        .out_tx_good  (out_tx_good),
        .out_tx_bad   (out_tx_bad),
        .out_rx_bytes (out_rx_bytes),
        .out_rx_good  (out_rx_good),
        .out_rx_bad   (out_rx_bad),
        .occupancy    (occupancy),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        srst         = 1'b0;
        enable       = 1'b1;
        pop          = 1'b0;
        current_time = 64'd0;
        tx_bytes     = 64'd0;
        tx_good      = 64'd0;
        tx_bad       = 64'd0;
        rx_bytes     = 64'd0;
        rx_good      = 64'd0;
        rx_bad       = 64'd0;

        // Reset state
        tick();
        tick();
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_time", out_time, 64'd0);
        check("rst_out_tx_good", out_tx_good, 64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_occupancy", 64'(occupancy), 64'd0);

        // Single change at time 100, occupancy 1 a cycle later, then pop
        tx_good      = 64'd1;
        current_time = 64'd100;
        tick();
        current_time = 64'd200;
        tick();
        check("single_occupancy", 64'(occupancy), 64'd1);
        do_pop();
        check("single_out_tx_good", out_tx_good, 64'd1);
        check("single_out_time", out_time, 64'd100);
        check("single_occ_after_pop", 64'(occupancy), 64'd0);

        // Pop on empty FIFO holds everything
        do_pop();
        check("empty_pop_out_tx_good", out_tx_good, 64'd1);
        check("empty_pop_out_time", out_time, 64'd100);
        check("empty_pop_occupancy", 64'(occupancy), 64'd0);

        // enable=0: five changes, nothing captured
        enable = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tx_bytes = 64'(i);
            tick();
        end
        tick();
        tick();
        enable = 1'b1;
        tick();
        tick();
        check("disabled_occupancy", 64'(occupancy), 64'd0);
        check("disabled_overflow", 64'(overflow), 64'd0);

        // Five back-to-back changes into a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            rx_good      = 64'(10 + i);
            current_time = 64'(1000 + i);
            tick();
        end
        tick();
        tick();
        check("full_occupancy", 64'(occupancy), 64'd4);
        check("full_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            do_pop();
            check($sformatf("drain%0d_rx_good", i), out_rx_good, 64'(10 + i));
            check($sformatf("drain%0d_time", i), out_time, 64'(1000 + i));
            check($sformatf("drain%0d_tx_bytes", i), out_tx_bytes, 64'd5);
            check($sformatf("drain%0d_occupancy", i), 64'(occupancy), 64'(3 - i));
        end
        do_pop();
        check("drain_extra_rx_good", out_rx_good, 64'd13);
        check("drain_extra_time", out_time, 64'd1003);
        check("drain_extra_occupancy", 64'(occupancy), 64'd0);

        // Three entries, then srst
        for (int i = 0; i < 3; i++) begin
            rx_good      = 64'(20 + i);
            current_time = 64'(2000 + i);
            tick();
        end
        tick();
        tick();
        check("pre_srst_occupancy", 64'(occupancy), 64'd3);
        check("pre_srst_overflow", 64'(overflow), 64'd1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("srst_occupancy", 64'(occupancy), 64'd0);
        check("srst_overflow", 64'(overflow), 64'd0);
        check("srst_out_rx_good", out_rx_good, 64'd0);
        check("srst_out_time", out_time, 64'd0);
        check("srst_out_tx_good", out_tx_good, 64'd0);
        // Nonzero inputs against the cleared prev count as a change
        current_time = 64'd3000;
        tick();
        current_time = 64'd3100;
        tick();
        check("post_srst_occupancy", 64'(occupancy), 64'd1);
        do_pop();
        check("post_srst_out_time", out_time, 64'd3000);
        check("post_srst_out_rx_good", out_rx_good, 64'd22);
        check("post_srst_out_tx_bytes", out_tx_bytes, 64'd5);

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            rx_good      = 64'(30 + i);
            current_time = 64'(4000 + i);
            tick();
        end
        tick();
        tick();
        check("refill_occupancy", 64'(occupancy), 64'd4);
        check("refill_overflow", 64'(overflow), 64'd0);
        rx_good      = 64'd34;
        current_time = 64'd4004;
        tick();
        do_pop();
        check("pushpop_occupancy", 64'(occupancy), 64'd4);
        check("pushpop_overflow", 64'(overflow), 64'd0);
        check("pushpop_out_rx_good", out_rx_good, 64'd30);
        check("pushpop_out_time", out_time, 64'd4000);
        for (int i = 1; i <= 4; i++) begin
            do_pop();
            check($sformatf("pushpop_drain%0d_rx_good", i), out_rx_good, 64'(30 + i));
            check($sformatf("pushpop_drain%0d_time", i), out_time, 64'(4000 + i));
        end
        check("pushpop_final_occupancy", 64'(occupancy), 64'd0);

        // Asynchronous reset between clock edges
        rx_good = 64'd40;
        tick();
        tick();
        check("pre_async_occupancy", 64'(occupancy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_occupancy", 64'(occupancy), 64'd0);
        check("async_rst_out_rx_good", out_rx_good, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
